ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, consuming the operand and control fields registered by the ID/EX pipeline register. It executes MULT/MULTU/DIV/DIVU over multiple cycles, owns the architectural HI/LO registers, and raises `busy` so the hazard unit can stall dependent MFHI/MFLO and new mul/div instructions. One operation is in flight at a time, and a pipeline flush can abort it.

---
 rtl/ex_muldiv_unit_if.sv | 26 ++
 rtl/ex_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: operand/control bundle between EX decode and the
// multiply/divide unit, plus the HI/LO and status returned to the pipeline.
interface ex_muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        cancel;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mtData;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, opA, opB, cancel, mthi, mtlo, mtData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, opA, opB, cancel, mthi, mtlo, mtData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational
// product and skip straight to FIX; divides stay iterative.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo accepted here
// CALC  | one multiplier bit or quotient bit per cycle, 32 cycles
// FIX   | sign correction, HI/LO write, done pulse
module ex_muldiv_unit (
  input  logic               clk,
  input  logic               rst,
  ex_muldiv_unit_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic [63:0] acc, acc_nx;
  logic [31:0] opb_reg, opb_nx;
  logic        is_div, is_div_nx;
  logic        neg_q, neg_q_nx;
  logic        neg_r, neg_r_nx;
  logic [31:0] hi_q, hi_nx;
  logic [31:0] lo_q, lo_nx;
  logic        busy_q, done_q, done_nx;

  logic        sgn;
  logic [31:0] a_abs, b_abs;
  logic [32:0] add_sum;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  // Operand magnitudes and per-iteration datapath terms.
  always_comb begin
    sgn      = ~bus.op[0];
    a_abs    = (sgn && bus.opA[31]) ? -bus.opA : bus.opA;
    b_abs    = (sgn && bus.opB[31]) ? -bus.opB : bus.opB;
    add_sum  = {1'b0, acc[63:32]} + {1'b0, opb_reg};
    rem_sh   = acc[63:31];
    rem_ge   = (rem_sh >= {1'b0, opb_reg});
    // Only used when rem_ge, so the difference is below opb_reg and fits 32 bits.
    rem_sub  = rem_sh[31:0] - opb_reg;
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[31:0] : acc[31:0];
    r_fix    = neg_r ? -acc[63:32] : acc[63:32];
  end

`ifdef MULDIV_FAST_MUL_EN
  // Full-width product for the single-cycle multiply path.
  always_comb begin
    fast_prod = {32'b0, a_abs} * {32'b0, b_abs};
  end
`endif

  // Next-state, iteration datapath and HI/LO update.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    opb_nx    = opb_reg;
    is_div_nx = is_div;
    neg_q_nx  = neg_q;
    neg_r_nx  = neg_r;
    hi_nx     = hi_q;
    lo_nx     = lo_q;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mthi) hi_nx = bus.mtData;
        if (bus.mtlo) lo_nx = bus.mtData;
        if (bus.start && !bus.cancel) begin
          cnt_nx    = 6'd0;
          opb_nx    = b_abs;
          is_div_nx = bus.op[1];
          // Divide by zero keeps the all-ones quotient unsigned so LO reads 0xFFFFFFFF.
          neg_q_nx  = sgn & (bus.opA[31] ^ bus.opB[31]) & (~bus.op[1] | (bus.opB != 32'd0));
          neg_r_nx  = sgn & bus.opA[31];
          acc_nx    = {32'b0, a_abs};
          state_nx  = CALC;
`ifdef MULDIV_FAST_MUL_EN
          if (!bus.op[1]) begin
            acc_nx   = fast_prod;
            state_nx = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 6'd1;
          if (is_div)
            acc_nx = rem_ge ? {rem_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
          else
            acc_nx = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};
          if (cnt == 6'd31) state_nx = FIX;
        end
      end
      FIX: begin
        state_nx = IDLE;
        if (!bus.cancel) begin
          done_nx = 1'b1;
          if (is_div) begin
            hi_nx = r_fix;
            lo_nx = q_fix;
          end else begin
            hi_nx = prod_fix[63:32];
            lo_nx = prod_fix[31:0];
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      acc     <= 64'd0;
      opb_reg <= 32'd0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      acc     <= acc_nx;
      opb_reg <= opb_nx;
      is_div  <= is_div_nx;
      neg_q   <= neg_q_nx;
      neg_r   <= neg_r_nx;
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
      busy_q  <= (state_nx != IDLE);
      done_q  <= done_nx;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [1:0] LONG_OP = 2'b11;
`else
  localparam int MUL_LAT = 33;
  localparam logic [1:0] LONG_OP = 2'b01;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  ex_muldiv_unit_if bus();

  ex_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] p;
    case (op)
      2'b00: begin
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        p = 64'(sa * sb_);
      end
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFFFFFF};
        end else begin
          if (op == 2'b10) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
          end else begin
            sa = longint'({32'b0, a});
            sb_ = longint'({32'b0, b});
          end
          q = sa / sb_;
          r = sa % sb_;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Compare each done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {bus.hi, bus.lo}, e);
      end
    end
  end

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = model(op, a, b);
    sb.push_back(e);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  // Called #1 after the launch edge; counts busy cycles and checks done.
  task automatic wait_idle(input int lat);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_len", 64'(n), 64'(lat));
    chk("done_pulse", {63'b0, bus.done}, 64'd1);
    @(posedge clk); #1;
    chk("done_clr", {63'b0, bus.done}, 64'd0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.opA = a; bus.opB = b; bus.start = 1'b1;
    push_exp(op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(op[1] ? 33 : MUL_LAT);
  endtask

  task automatic launch_untracked(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.opA = a; bus.opB = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    bus.start = 0; bus.op = 0; bus.opA = 0; bus.opB = 0;
    bus.cancel = 0; bus.mthi = 0; bus.mtlo = 0; bus.mtData = 0;
    m_hi = 0; m_lo = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_done", {63'b0, bus.done}, 64'd0);
    chk("rst_hi", {32'b0, bus.hi}, 64'd0);
    chk("rst_lo", {32'b0, bus.lo}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(2'b00, 32'hFFFFFFFD, 32'd5);
    do_op(2'b11, 32'd100, 32'd7);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2);
    do_op(2'b10, 32'h12345678, 32'd0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    do_op(2'b11, 32'h87654321, 32'd0);
    do_op(2'b10, 32'hFFFFFFF9, 32'd0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(2'b00, 32'h00010000, 32'h00010000);
    do_op(2'b00, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) a = 32'hFFFFFF00;
      do_op(op, a, b);
    end

    // start and mthi while busy must not disturb the running divide
    a = m_hi;
    bus.op = 2'b11; bus.opA = 32'd1000; bus.opB = 32'd10; bus.start = 1'b1;
    push_exp(2'b11, 32'd1000, 32'd10);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.op = 2'b00; bus.opA = 32'd7; bus.opB = 32'd7; bus.start = 1'b1;
    bus.mthi = 1'b1; bus.mtData = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mthi = 1'b0;
    chk("mthi_busy", {32'b0, bus.hi}, {32'b0, a});
    wait_idle(28);
    chk("no_relaunch", {63'b0, bus.busy}, 64'd0);

    bus.mthi = 1'b1; bus.mtData = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    m_hi = 32'hA5A5A5A5;
    chk("mthi_idle", {32'b0, bus.hi}, 64'h00000000A5A5A5A5);
    bus.mtlo = 1'b1; bus.mtData = 32'h5A5A1234;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    m_lo = 32'h5A5A1234;
    chk("mtlo_idle", {32'b0, bus.lo}, 64'h000000005A5A1234);

    bus.mthi = 1'b1; bus.mtData = 32'h11112222;
    bus.op = 2'b11; bus.opA = 32'd77; bus.opB = 32'd5; bus.start = 1'b1;
    push_exp(2'b11, 32'd77, 32'd5);
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.start = 1'b0;
    chk("mthi_with_start", {32'b0, bus.hi}, 64'h0000000011112222);
    wait_idle(33);

    // cancel mid-operation
    launch_untracked(LONG_OP, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cancel_busy", {63'b0, bus.busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("cancel_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    do_op(2'b01, 32'd6, 32'd9);

    // cancel beats start in IDLE
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b10; bus.opA = 32'd5; bus.opB = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("cancel_wins", {63'b0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    chk("cancel_wins_hold", {63'b0, bus.busy}, 64'd0);

    // reset mid-CALC
    launch_untracked(2'b10, 32'h7FFFFFFF, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_hi = 0; m_lo = 0;
    chk("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_idle", {63'b0, bus.busy}, 64'd0);
    do_op(2'b00, 32'h00000003, 32'hFFFFFFFE);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
